// File: rtl/pwm_breath_pkg.sv
// Shared definitions for the multi-channel breathing PWM: mode encodings,
// ramp direction and the per-channel start-duty (phase offset) helper.
package pwm_breath_pkg;

  localparam logic MODE_FIXED  = 1'b0;
  localparam logic MODE_BREATH = 1'b1;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Channels start evenly spread over the duty range so they breathe out of phase.
  function automatic int unsigned phase_offset(input int unsigned idx,
                                               input int unsigned cnt_w,
                                               input int unsigned ch);
    return idx * ((32'd1 << cnt_w) / ch);
  endfunction

endpackage

// File: rtl/pwm_breath_multi_chan.sv
// One PWM channel: duty/direction registers, breathing step rule and the
// registered compare output. Duty only changes when the top strobes load/step.
module pwm_breath_chan
  import pwm_breath_pkg::*;
#(
  parameter int unsigned CNT_W     = 6,
  parameter int unsigned INIT_DUTY = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [CNT_W-1:0] duty_in_i,
  input  logic [CNT_W-1:0] cnt_i,
  output logic             pwm_o,
  output logic [CNT_W-1:0] duty_o
);

  localparam logic [CNT_W-1:0] DMAX   = '1;
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] INIT_D = CNT_W'(INIT_DUTY);

  logic [CNT_W-1:0] duty_q, duty_d;
  dir_e             dir_q,  dir_d;
  logic             pwm_q,  pwm_d;

  always_comb begin
    duty_d = duty_q;
    dir_d  = dir_q;
    if (load_i) begin
      duty_d = duty_in_i;
    end else if (step_i) begin
      // Reversal happens on the step itself, so neither end holds for two steps.
      case (dir_q)
        DIR_UP: begin
          if (duty_q == DMAX) begin
            dir_d  = DIR_DOWN;
            duty_d = DMAX - ONE;
          end else begin
            duty_d = duty_q + ONE;
          end
        end
        DIR_DOWN: begin
          if (duty_q == '0) begin
            dir_d  = DIR_UP;
            duty_d = ONE;
          end else begin
            duty_d = duty_q - ONE;
          end
        end
        default: begin
          dir_d  = DIR_UP;
          duty_d = duty_q;
        end
      endcase
    end
    pwm_d = enable_i && (cnt_i < duty_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      duty_q <= INIT_D;
      dir_q  <= DIR_UP;
      pwm_q  <= 1'b0;
    end else begin
      duty_q <= duty_d;
      dir_q  <= dir_d;
      pwm_q  <= pwm_d;
    end
  end

  assign pwm_o  = pwm_q;
  assign duty_o = duty_q;

endmodule

// File: rtl/pwm_breath_multi.sv
// Multi-channel breathing PWM: shared period counter, step prescaler and CH
// compare channels. Define PWM_CENTER_ALIGN_EN for an up/down (centred) counter.
module pwm_breath_multi
  import pwm_breath_pkg::*;
#(
  parameter int unsigned CNT_W   = 6,
  parameter int unsigned CH      = 4,
  parameter int unsigned PRESC_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               mode,
  input  logic [CNT_W-1:0]   duty_in,
  input  logic [PRESC_W-1:0] step_div,
  output logic [CH-1:0]      pwm_out,
  output logic [CNT_W-1:0]   duty_ch0,
  output logic               period_tick
);

  localparam logic [CNT_W-1:0]   DMAX = '1;
  localparam logic [CNT_W-1:0]   ONE  = CNT_W'(1);
  localparam logic [PRESC_W-1:0] PONE = PRESC_W'(1);

  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               tick_q,  tick_d;
  logic               boundary, presc_match, load, step;
`ifdef PWM_CENTER_ALIGN_EN
  dir_e               cdir_q,  cdir_d;
`endif

  always_comb begin
    cnt_d   = cnt_q;
    presc_d = presc_q;
`ifdef PWM_CENTER_ALIGN_EN
    cdir_d  = cdir_q;
    if (enable) begin
      if (cdir_q == DIR_UP) begin
        if (cnt_q == DMAX) begin
          cnt_d  = DMAX - ONE;
          cdir_d = (DMAX == ONE) ? DIR_UP : DIR_DOWN;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end else begin
        cnt_d = cnt_q - ONE;
        if (cnt_q == ONE) cdir_d = DIR_UP;
      end
    end
`else
    if (enable) cnt_d = cnt_q + ONE;
`endif
    // Period boundary is the last cycle before the counter returns to zero.
    boundary    = enable && (cnt_q != '0) && (cnt_d == '0);
    presc_match = (presc_q >= step_div);
    load        = boundary && (mode == MODE_FIXED);
    step        = boundary && (mode == MODE_BREATH) && presc_match;
    if (boundary && (mode == MODE_BREATH)) begin
      presc_d = presc_match ? '0 : presc_q + PONE;
    end
    tick_d = boundary;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      presc_q <= '0;
      tick_q  <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
      cdir_q  <= DIR_UP;
`endif
    end else begin
      cnt_q   <= cnt_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
`ifdef PWM_CENTER_ALIGN_EN
      cdir_q  <= cdir_d;
`endif
    end
  end

  assign period_tick = tick_q;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [CNT_W-1:0] duty_w;

    pwm_breath_chan #(
      .CNT_W     (CNT_W),
      .INIT_DUTY (phase_offset(i, CNT_W, CH))
    ) u_chan (
      .clk_i     (clk),
      .rst_ni    (reset_n),
      .enable_i  (enable),
      .load_i    (load),
      .step_i    (step),
      .duty_in_i (duty_in),
      .cnt_i     (cnt_q),
      .pwm_o     (pwm_out[i]),
      .duty_o    (duty_w)
    );

    if (i == 0) begin : g_obs
      assign duty_ch0 = duty_w;
    end else begin : g_rest
      logic [CNT_W-1:0] unused_duty;
      assign unused_duty = duty_w;
    end
  end

endmodule

// File: tb/tb_pwm_breath_multi.sv
// Scoreboard bench for pwm_breath_multi (edge-aligned build, CNT_W=6, CH=4).
module tb_pwm_breath_multi;

  localparam int CNT_W = 6;
  localparam int CH    = 4;
  localparam int PRESC_W = 4;
  localparam int DMAX  = 63;
  localparam int PER   = 64;

  logic               clk = 1'b0;
  logic               reset_n = 1'b1;
  logic               enable = 1'b0;
  logic               mode = 1'b0;
  logic [CNT_W-1:0]   duty_in = '0;
  logic [PRESC_W-1:0] step_div = '0;
  logic [CH-1:0]      pwm_out;
  logic [CNT_W-1:0]   duty_ch0;
  logic               period_tick;

  always #5 clk = ~clk;

  pwm_breath_multi #(.CNT_W(CNT_W), .CH(CH), .PRESC_W(PRESC_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .mode        (mode),
    .duty_in     (duty_in),
    .step_div    (step_div),
    .pwm_out     (pwm_out),
    .duty_ch0    (duty_ch0),
    .period_tick (period_tick)
  );

  typedef struct packed {
    logic [CH-1:0]    pwm;
    logic             tick;
    logic [CNT_W-1:0] duty0;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nerr = 0;
  bit   obs_pwm0, obs_tick;

  // Reference model: counter as an integer, breathing as a position on a triangle wave.
  int m_cnt, m_presc;
  int m_duty[CH];
  bit m_up[CH];

  function automatic void model_reset();
    m_cnt = 0;
    m_presc = 0;
    for (int i = 0; i < CH; i++) begin
      m_duty[i] = i * (PER / CH);
      m_up[i]   = 1'b1;
    end
    sb.delete();
  endfunction

  function automatic void wave_step(input int i);
    int p;
    p = m_up[i] ? m_duty[i] : 2 * DMAX - m_duty[i];
    p = (p + 1) % (2 * DMAX);
    m_duty[i] = (p <= DMAX) ? p : 2 * DMAX - p;
    m_up[i]   = (p >= 1) && (p <= DMAX);
  endfunction

  task automatic chk(input string name, input int act, input int req);
    nvec++;
    if (act != req) begin
      nerr++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // One clock of stimulus; records the outputs of the previous edge first.
  task automatic cyc(input bit en, input bit md, input int din, input int div);
    exp_t e;
    @(negedge clk);
    obs_pwm0 = pwm_out[0];
    obs_tick = period_tick;
    enable   = en;
    mode     = md;
    duty_in  = CNT_W'(din);
    step_div = PRESC_W'(div);
    for (int i = 0; i < CH; i++) e.pwm[i] = en && (m_cnt < m_duty[i]);
    e.tick = en && (m_cnt == DMAX);
    if (en) begin
      if (m_cnt == DMAX) begin
        if (!md) begin
          for (int i = 0; i < CH; i++) m_duty[i] = din;
        end else if (m_presc >= div) begin
          m_presc = 0;
          for (int i = 0; i < CH; i++) wave_step(i);
        end else begin
          m_presc++;
        end
      end
      m_cnt = (m_cnt + 1) % PER;
    end
    e.duty0 = CNT_W'(m_duty[0]);
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("reset_pwm", int'(pwm_out), 0);
    chk("reset_tick", int'(period_tick), 0);
    chk("reset_duty0", int'(duty_ch0), 0);
    @(posedge clk);
    @(posedge clk);
    #3 reset_n = 1'b1;
    model_reset();
  endtask

  task automatic wait_tick(input int din);
    int k;
    k = 0;
    do begin
      cyc(1'b1, 1'b0, din, 0);
      k++;
    end while (!obs_tick && k < 200);
    chk("tick_found", int'(obs_tick), 1);
  endtask

  task automatic fixed_window(input int d);
    int hi, tk;
    for (int k = 0; k < 130; k++) cyc(1'b1, 1'b0, d, 0);
    hi = 0;
    tk = 0;
    for (int k = 0; k < PER; k++) begin
      cyc(1'b1, 1'b0, d, 0);
      hi += int'(obs_pwm0);
      tk += int'(obs_tick);
    end
    chk($sformatf("fixed%0d_high", d), hi, d);
    chk($sformatf("fixed%0d_ticks", d), tk, 1);
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        nvec++;
        if (pwm_out !== e.pwm || period_tick !== e.tick || duty_ch0 !== e.duty0) begin
          nerr++;
          $display("FAIL cycle@%0t: pwm=%b tick=%b duty0=%0d, required pwm=%b tick=%b duty0=%0d",
                   $time, pwm_out, period_tick, duty_ch0, e.pwm, e.tick, e.duty0);
        end
      end
    end
  end

  initial begin : stim
    int hi, tk, k;
    model_reset();
    #2 reset_n = 1'b0;
    #1;
    chk("por_pwm", int'(pwm_out), 0);
    chk("por_tick", int'(period_tick), 0);
    @(posedge clk);
    #3 reset_n = 1'b1;
    model_reset();

    // Breathing, step every period: ch0 ramps 0..63 then back down.
    for (int j = 0; j < 40 * PER; j++) cyc(1'b1, 1'b1, 0, 0);
    @(posedge clk); #2;
    chk("breath_ch0_at40", int'(duty_ch0), 40);
    for (int j = 0; j < 70 * PER; j++) cyc(1'b1, 1'b1, 0, 0);
    @(posedge clk); #2;
    chk("breath_ch0_at110", int'(duty_ch0), 16);

    // Prescaled breathing: one step per 4 periods.
    do_reset();
    for (int j = 0; j < 8 * PER; j++) cyc(1'b1, 1'b1, 0, 3);
    @(posedge clk); #2;
    chk("presc3_ch0", int'(duty_ch0), 2);
    // Shrinking step_div below the running prescaler forces an immediate step.
    for (int j = 0; j < 5 * PER; j++) cyc(1'b1, 1'b1, 0, 7);
    for (int j = 0; j < 2 * PER; j++) cyc(1'b1, 1'b1, 0, 2);

    // Fixed-duty windows including both ends of the range.
    fixed_window(16);
    fixed_window(0);
    fixed_window(DMAX);

    // Duty change mid-period only takes effect in the following period.
    for (int j = 0; j < 130; j++) cyc(1'b1, 1'b0, 16, 0);
    wait_tick(16);
    hi = int'(obs_pwm0);
    for (int j = 1; j < PER; j++) begin
      cyc(1'b1, 1'b0, (j >= 20) ? 40 : 16, 0);
      hi += int'(obs_pwm0);
    end
    chk("midchg_cur_period", hi, 16);
    hi = 0;
    tk = 0;
    for (int j = 0; j < PER; j++) begin
      cyc(1'b1, 1'b0, 40, 0);
      hi += int'(obs_pwm0);
      tk += int'(obs_tick);
    end
    chk("midchg_next_period", hi, 40);
    chk("midchg_ticks", tk, 1);

    // Enable dropped mid-period, then resumed.
    k = 0;
    while (m_cnt != 30 && k < 200) begin
      cyc(1'b1, 1'b1, 0, 0);
      k++;
    end
    chk("reach_cnt30", m_cnt, 30);
    for (int j = 0; j < 10; j++) cyc(1'b0, 1'b1, 0, 0);
    for (int j = 0; j < 2 * PER; j++) cyc(1'b1, 1'b1, 0, 0);

    // Randomised mixed operation.
    begin
      bit rm;
      int rd, rv;
      rm = 1'b1; rd = 0; rv = 0;
      for (int j = 0; j < 3000; j++) begin
        if (j % 200 == 0) begin
          rm = 1'($urandom_range(0, 1));
          rd = int'($urandom_range(0, DMAX));
          rv = int'($urandom_range(0, 3));
        end
        cyc(($urandom_range(0, 9) != 0), rm, rd, rv);
      end
    end

    // Reset mid-period, then breathing from the reset phase offsets.
    do_reset();
    for (int j = 0; j < 20 * PER; j++) cyc(1'b1, 1'b1, 0, 0);

    @(posedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
